fetch_unit_param: RTL and testbench
===================================

Name: fetch_unit_param

Overview:
Parametrised LC-3 instruction fetch unit, the successor of the fixed-width fetch block. It owns the PC and computes next-PC for BR, JMP/RET and JSR/JSRR. It fetches instructions over a request/acknowledge memory port that tolerates variable memory latency, and raises a sticky error when the memory does not respond. It sits between the control FSM (fetch_start, pc_update) and the unified memory.

Parameters:
ADDR_W, 16, PC and memory address width
DATA_W, 16, instruction/data width
OFF9_W, 9, BR offset width (sign-extended)
OFF11_W, 11, JSR offset width (sign-extended)
PC_RESET, 0, PC value after reset
TIMEOUT, 16, cycles in WAIT without mem_ack before abort (>=1)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
fetch_start  in  1  pulse: start instruction fetch at PC
pc_update  in  1  pulse: apply control-flow change from opCode_in
opCode_in  in  4  opcode of executed instruction (0000 BR, 1100 JMP/RET, 0100 JSR/JSRR)
jsr_mode  in  1  for 0100: 1=JSR (PC+off11), 0=JSRR (reg_in)
offset9_in  in  OFF9_W  BR offset
offset11_in  in  OFF11_W  JSR offset
reg_in  in  ADDR_W  base register value for JMP/JSRR
br_nzp  in  3  BR condition mask
result_nzp  in  3  current condition codes
mem_rdata  in  DATA_W  memory read data
mem_ack  in  1  memory response valid
mem_addr  out  ADDR_W  memory address
mem_req  out  1  memory request
mem_we  out  1  memory write enable, tied 0 by this block
instr_out  out  DATA_W  fetched instruction
instr_valid  out  1  one-cycle pulse: instr_out valid
pc  out  ADDR_W  program counter
link_out  out  ADDR_W  return address for JSR/JSRR
link_valid  out  1  one-cycle pulse with link_out
busy  out  1  high in WAIT
fetch_err  out  1  sticky memory-timeout flag

Behaviour:
- Reset (rst=1 at edge, any state): pc=PC_RESET. mem_addr, instr_out and link_out=0. mem_req, mem_we, instr_valid, link_valid, busy and fetch_err=0. State=IDLE, timeout counter=0.
- next_pc (combinational), only when pc_update=1:
  - BR: pc+sext(offset9_in) if |(br_nzp & result_nzp), else pc.
  - JMP: reg_in.
  - JSR: pc+sext(offset11_in).
  - JSRR: reg_in.
  - Other opcodes: pc.
  - When pc_update=0: pc.
- All adds are modulo 2^ADDR_W.
- IDLE:
  - pc_update=1: pc<=next_pc. For 0100, link_out<=pc (old, already incremented) and link_valid=1 for one cycle.
  - fetch_start=1: mem_addr<=next_pc, mem_req<=1, busy<=1, fetch_err<=0, counter<=0, go to WAIT.
  - Simultaneous pc_update and fetch_start: both actions apply; the fetch uses the updated PC.
- WAIT:
  - mem_req and mem_addr are held stable.
  - fetch_start and pc_update are ignored (not queued).
  - mem_ack=1 at an edge: instr_out<=mem_rdata, instr_valid=1 for the next cycle only, pc<=pc+1 (FFFF wraps to 0000), mem_req<=0, busy<=0, go to IDLE.
  - No ack: counter increments. When counter reaches TIMEOUT-1 without ack: mem_req<=0, busy<=0, fetch_err<=1, pc unchanged, instr_valid stays 0, go to IDLE.
  - mem_ack while in IDLE is ignored.
- Latency: fetch_start sampled at edge E gives mem_req high after E. An ack sampled at E+k (k>=1) gives instr_valid high after E+k. Minimum fetch_start-to-instr_valid is 2 cycles.
- Reset mid-WAIT: request dropped immediately and no instr_valid is produced.
- mem_we is 0 in every state.

Test Plan:
- rst=1 for 5 cycles then 0, fetch_start=0, opCode_in=0000 -> pc=0, mem_addr=0, mem_we=0, mem_req=0, instr_valid=0, fetch_err=0, held for 10 cycles.
- fetch_start at pc=0, mem_ack 3 cycles after mem_req with mem_rdata=16'h1234 -> mem_addr=0 during WAIT, instr_out=16'h1234, instr_valid high exactly 1 cycle, pc=1, busy low afterwards.
- BRzp at pc=5, offset9=-3, br_nzp=011:
  - result_nzp=100 -> pc stays 5.
  - Repeat with result_nzp=010 -> pc=2.
  - result_nzp=001 -> pc=2.
- JMP reg_in=16'h4000 -> pc=16'h4000. Then JSR (jsr_mode=1) at pc=16'h3001 with offset11=11'h7FF -> pc=16'h3000, link_out=16'h3001, link_valid 1 cycle. JSRR reg_in=16'h5000 -> pc=16'h5000.
- TIMEOUT=8, fetch_start, mem_ack never asserted -> mem_req drops after 8 cycles, fetch_err=1, pc unchanged. Next fetch_start clears fetch_err. An ack then increments pc.
- Boundary cases:
  - pc=16'hFFFF fetch -> pc=16'h0000.
  - pc_update (BR taken, target 16'h0010) with fetch_start in the same cycle -> mem_addr=16'h0010.
  - rst asserted in WAIT -> mem_req=0 next cycle, no instr_valid.
  - fetch_start in WAIT -> ignored, single instr_valid only.

Source files
------------

// File: rtl/fetch_unit_param.sv
// LC-3 instruction fetch unit: owns the PC, resolves BR/JMP/JSR/JSRR targets
// and fetches instructions over a req/ack memory port with a response timeout.
module fetch_unit_param #(
   parameter int unsigned ADDR_W   = 16,
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned OFF9_W   = 9,
   parameter int unsigned OFF11_W  = 11,
   parameter int unsigned PC_RESET = 0,
   parameter int unsigned TIMEOUT  = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               fetch_start,
   input  logic               pc_update,
   input  logic [3:0]         opCode_in,
   input  logic               jsr_mode,
   input  logic [OFF9_W-1:0]  offset9_in,
   input  logic [OFF11_W-1:0] offset11_in,
   input  logic [ADDR_W-1:0]  reg_in,
   input  logic [2:0]         br_nzp,
   input  logic [2:0]         result_nzp,
   input  logic [DATA_W-1:0]  mem_rdata,
   input  logic               mem_ack,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic               mem_req,
   output logic               mem_we,
   output logic [DATA_W-1:0]  instr_out,
   output logic               instr_valid,
   output logic [ADDR_W-1:0]  pc,
   output logic [ADDR_W-1:0]  link_out,
   output logic               link_valid,
   output logic               busy,
   output logic               fetch_err
);

   // Counter only needs to reach TIMEOUT-1
   localparam int unsigned       CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [ADDR_W-1:0] PC_INIT  = ADDR_W'(PC_RESET);
   localparam logic [3:0]        OP_BR    = 4'b0000;
   localparam logic [3:0]        OP_JMP   = 4'b1100;
   localparam logic [3:0]        OP_JSR   = 4'b0100;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [ADDR_W-1:0]   pc_d, mem_addr_d, link_out_d;
   logic [DATA_W-1:0]   instr_out_d;
   logic                mem_req_d, instr_valid_d, link_valid_d, busy_d, fetch_err_d;
   logic [ADDR_W-1:0]   off9_sext_c, off11_sext_c, next_pc_c;

   assign off9_sext_c  = ADDR_W'($signed(offset9_in));
   assign off11_sext_c = ADDR_W'($signed(offset11_in));

   // Control-flow target; equals pc unless a taken update is presented
   always_comb begin
      next_pc_c = pc;
      if (pc_update) begin
         case (opCode_in)
            OP_BR:   if (|(br_nzp & result_nzp)) next_pc_c = pc + off9_sext_c;
            OP_JMP:  next_pc_c = reg_in;
            OP_JSR:  next_pc_c = jsr_mode ? (pc + off11_sext_c) : reg_in;
            default: next_pc_c = pc;
         endcase
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      pc_d          = pc;
      mem_addr_d    = mem_addr;
      mem_req_d     = mem_req;
      instr_out_d   = instr_out;
      instr_valid_d = 1'b0;
      link_out_d    = link_out;
      link_valid_d  = 1'b0;
      busy_d        = busy;
      fetch_err_d   = fetch_err;

      case (state_q)
         S_IDLE: begin
            if (pc_update) begin
               pc_d = next_pc_c;
               if (opCode_in == OP_JSR) begin
                  link_out_d   = pc;
                  link_valid_d = 1'b1;
               end
            end
            if (fetch_start) begin
               mem_addr_d  = next_pc_c;
               mem_req_d   = 1'b1;
               busy_d      = 1'b1;
               fetch_err_d = 1'b0;
               cnt_d       = '0;
               state_d     = S_WAIT;
            end
         end
         S_WAIT: begin
            if (mem_ack) begin
               instr_out_d   = mem_rdata;
               instr_valid_d = 1'b1;
               pc_d          = pc + ADDR_W'(1);
               mem_req_d     = 1'b0;
               busy_d        = 1'b0;
               state_d       = S_IDLE;
            end else if (cnt_q == CNT_LAST) begin
               mem_req_d   = 1'b0;
               busy_d      = 1'b0;
               fetch_err_d = 1'b1;
               state_d     = S_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         pc          <= PC_INIT;
         mem_addr    <= '0;
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         instr_out   <= '0;
         instr_valid <= 1'b0;
         link_out    <= '0;
         link_valid  <= 1'b0;
         busy        <= 1'b0;
         fetch_err   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pc          <= pc_d;
         mem_addr    <= mem_addr_d;
         mem_req     <= mem_req_d;
         mem_we      <= 1'b0;
         instr_out   <= instr_out_d;
         instr_valid <= instr_valid_d;
         link_out    <= link_out_d;
         link_valid  <= link_valid_d;
         busy        <= busy_d;
         fetch_err   <= fetch_err_d;
      end
   end

endmodule

// File: tb/tb_fetch_unit_param.sv
// Scoreboard bench for fetch_unit_param: directed scenarios plus random traffic.
module tb_fetch_unit_param;

   localparam int unsigned AW = 16;
   localparam int unsigned DW = 16;
   localparam int unsigned TO = 8;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           fetch_start = 1'b0;
   logic           pc_update = 1'b0;
   logic [3:0]     opCode_in = 4'b0000;
   logic           jsr_mode = 1'b0;
   logic [8:0]     offset9_in = '0;
   logic [10:0]    offset11_in = '0;
   logic [AW-1:0]  reg_in = '0;
   logic [2:0]     br_nzp = '0;
   logic [2:0]     result_nzp = '0;
   logic [DW-1:0]  mem_rdata = '0;
   logic           mem_ack = 1'b0;
   logic [AW-1:0]  mem_addr;
   logic           mem_req, mem_we;
   logic [DW-1:0]  instr_out;
   logic           instr_valid;
   logic [AW-1:0]  pc, link_out;
   logic           link_valid, busy, fetch_err;

   fetch_unit_param #(
      .ADDR_W(AW), .DATA_W(DW), .OFF9_W(9), .OFF11_W(11), .PC_RESET(0), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst(rst), .fetch_start(fetch_start), .pc_update(pc_update),
      .opCode_in(opCode_in), .jsr_mode(jsr_mode), .offset9_in(offset9_in),
      .offset11_in(offset11_in), .reg_in(reg_in), .br_nzp(br_nzp),
      .result_nzp(result_nzp), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .mem_addr(mem_addr), .mem_req(mem_req), .mem_we(mem_we),
      .instr_out(instr_out), .instr_valid(instr_valid), .pc(pc),
      .link_out(link_out), .link_valid(link_valid), .busy(busy), .fetch_err(fetch_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] instr;
      logic [15:0] pc_after;
   } exp_t;

   exp_t        exp_q[$];
   logic [15:0] link_q[$];
   logic [15:0] mpc = 16'h0000;
   int          total = 0;
   int          bad = 0;

   task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b want %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference target computation from the ISA rules
   function automatic logic [15:0] model_target(input logic [3:0] op, input logic mode,
                                                input logic [8:0] o9, input logic [10:0] o11,
                                                input logic [15:0] r, input logic [2:0] b,
                                                input logic [2:0] n, input logic [15:0] cur);
      int s9, s11;
      s9 = int'(o9);
      if (o9 >= 9'd256) s9 -= 512;
      s11 = int'(o11);
      if (o11 >= 11'd1024) s11 -= 2048;
      case (op)
         4'b0000: return ((b & n) != 3'b000) ? 16'(int'(cur) + s9) : cur;
         4'b1100: return r;
         4'b0100: return mode ? 16'(int'(cur) + s11) : r;
         default: return cur;
      endcase
   endfunction

   // Monitor: pops expected responses whenever the DUT presents one
   always @(negedge clk) begin : monitor
      exp_t e;
      logic [15:0] l;
      if (instr_valid) begin
         if (exp_q.size() == 0) check1("spurious_instr_valid", 1'b1, 1'b0);
         else begin
            e = exp_q.pop_front();
            check16("instr_out", instr_out, e.instr);
            check16("pc_after_fetch", pc, e.pc_after);
         end
      end
      if (link_valid) begin
         if (link_q.size() == 0) check1("spurious_link_valid", 1'b1, 1'b0);
         else begin
            l = link_q.pop_front();
            check16("link_out", link_out, l);
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_update(input logic [3:0] op, input logic mode, input logic [8:0] o9,
                            input logic [10:0] o11, input logic [15:0] r, input logic [2:0] b,
                            input logic [2:0] n, input logic with_fetch);
      logic [15:0] t;
      opCode_in = op; jsr_mode = mode; offset9_in = o9; offset11_in = o11;
      reg_in = r; br_nzp = b; result_nzp = n;
      pc_update = 1'b1; fetch_start = with_fetch;
      t = model_target(op, mode, o9, o11, r, b, n, mpc);
      if (op == 4'b0100) link_q.push_back(mpc);
      mpc = t;
      tick();
      pc_update = 1'b0; fetch_start = 1'b0;
      check16("pc_update", pc, mpc);
   endtask

   // Called one step after the edge that accepted fetch_start
   task automatic fetch_body(input logic [15:0] data, input int lat);
      check1("req_after_start", mem_req, 1'b1);
      check16("mem_addr", mem_addr, mpc);
      check1("busy_in_wait", busy, 1'b1);
      for (int i = 1; i < lat; i++) begin
         tick();
         if (!mem_req || mem_addr !== mpc) check16("wait_hold_addr", mem_req ? mem_addr : 16'hDEAD, mpc);
      end
      mem_rdata = data; mem_ack = 1'b1;
      exp_q.push_back('{instr: data, pc_after: 16'(mpc + 16'd1)});
      mpc = 16'(mpc + 16'd1);
      tick();
      mem_ack = 1'b0; mem_rdata = 16'($urandom);
      check1("req_after_ack", mem_req, 1'b0);
      check1("busy_after_ack", busy, 1'b0);
   endtask

   task automatic do_fetch(input logic [15:0] data, input int lat);
      fetch_start = 1'b1;
      tick();
      fetch_start = 1'b0;
      fetch_body(data, lat);
   endtask

   initial begin : stim
      logic [3:0] op;
      int sel;

      // Reset and idle
      repeat (5) tick();
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (i == 0 || i == 9) begin
            check16("reset_pc", pc, 16'h0000);
            check16("reset_mem_addr", mem_addr, 16'h0000);
            check1("reset_mem_we", mem_we, 1'b0);
            check1("reset_mem_req", mem_req, 1'b0);
            check1("reset_instr_valid", instr_valid, 1'b0);
            check1("reset_fetch_err", fetch_err, 1'b0);
            check1("reset_busy", busy, 1'b0);
         end
      end

      // Basic fetch, ack three cycles into WAIT
      do_fetch(16'h1234, 3);
      check16("pc_after_first_fetch", pc, 16'h0001);

      // BRzp from pc=5, offset -3
      do_update(4'b1100, 1'b0, '0, '0, 16'h0005, 3'b000, 3'b000, 1'b0);
      do_update(4'b0000, 1'b0, 9'h1FD, '0, '0, 3'b011, 3'b100, 1'b0);
      check16("br_not_taken", pc, 16'h0005);
      do_update(4'b0000, 1'b0, 9'h1FD, '0, '0, 3'b011, 3'b010, 1'b0);
      check16("br_taken_z", pc, 16'h0002);
      do_update(4'b1100, 1'b0, '0, '0, 16'h0005, 3'b000, 3'b000, 1'b0);
      do_update(4'b0000, 1'b0, 9'h1FD, '0, '0, 3'b011, 3'b001, 1'b0);
      check16("br_taken_p", pc, 16'h0002);

      // JMP, JSR, JSRR
      do_update(4'b1100, 1'b0, '0, '0, 16'h4000, 3'b000, 3'b000, 1'b0);
      check16("jmp", pc, 16'h4000);
      do_update(4'b1100, 1'b0, '0, '0, 16'h3001, 3'b000, 3'b000, 1'b0);
      do_update(4'b0100, 1'b1, '0, 11'h7FF, '0, 3'b000, 3'b000, 1'b0);
      check16("jsr", pc, 16'h3000);
      do_update(4'b0100, 1'b0, '0, '0, 16'h5000, 3'b000, 3'b000, 1'b0);
      check16("jsrr", pc, 16'h5000);
      tick();

      // Timeout with no ack
      do_update(4'b1100, 1'b0, '0, '0, 16'h0200, 3'b000, 3'b000, 1'b0);
      fetch_start = 1'b1;
      tick();
      fetch_start = 1'b0;
      repeat (TO - 1) tick();
      check1("req_before_timeout", mem_req, 1'b1);
      tick();
      check1("req_after_timeout", mem_req, 1'b0);
      check1("err_after_timeout", fetch_err, 1'b1);
      check1("busy_after_timeout", busy, 1'b0);
      check16("pc_after_timeout", pc, 16'h0200);
      tick();
      fetch_start = 1'b1;
      tick();
      fetch_start = 1'b0;
      check1("err_cleared", fetch_err, 1'b0);
      fetch_body(16'hBEEF, 2);
      check16("pc_after_retry", pc, 16'h0201);

      // PC wrap at FFFF
      do_update(4'b1100, 1'b0, '0, '0, 16'hFFFF, 3'b000, 3'b000, 1'b0);
      do_fetch(16'h0F0F, 1);
      check16("pc_wrap", pc, 16'h0000);

      // Simultaneous BR update and fetch
      do_update(4'b1100, 1'b0, '0, '0, 16'h0014, 3'b000, 3'b000, 1'b0);
      do_update(4'b0000, 1'b0, 9'h1FC, '0, '0, 3'b111, 3'b010, 1'b1);
      check16("combined_mem_addr", mem_addr, 16'h0010);
      fetch_body(16'hA5A5, 2);

      // fetch_start and pc_update during WAIT are ignored
      fetch_start = 1'b1;
      tick();
      fetch_start = 1'b0;
      tick();
      fetch_start = 1'b1; pc_update = 1'b1; opCode_in = 4'b1100; reg_in = 16'h1234;
      tick();
      fetch_start = 1'b0; pc_update = 1'b0;
      check16("pc_held_in_wait", pc, mpc);
      fetch_body(16'h5A5A, 1);
      repeat (3) tick();
      check1("no_second_fetch", mem_req, 1'b0);

      // Reset in WAIT, then ack in IDLE ignored
      fetch_start = 1'b1;
      tick();
      fetch_start = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      mpc = 16'h0000;
      check1("rst_wait_req", mem_req, 1'b0);
      check1("rst_wait_busy", busy, 1'b0);
      check16("rst_wait_pc", pc, 16'h0000);
      mem_ack = 1'b1; mem_rdata = 16'hFFFF;
      tick();
      mem_ack = 1'b0;
      check16("ack_in_idle_pc", pc, 16'h0000);
      check1("ack_in_idle_valid", instr_valid, 1'b0);

      // Random traffic
      for (int it = 0; it < 60; it++) begin
         sel = int'($urandom_range(0, 2));
         case ($urandom_range(0, 4))
            0: op = 4'b0000;
            1: op = 4'b1100;
            2: op = 4'b0100;
            default: op = 4'($urandom_range(0, 15));
         endcase
         if (sel == 1) begin
            do_fetch(16'($urandom), int'($urandom_range(1, 5)));
         end else begin
            do_update(op, 1'($urandom), 9'($urandom), 11'($urandom), 16'($urandom),
                      3'($urandom), 3'($urandom), 1'(sel == 2));
            if (sel == 2) begin
               check16("rand_combined_addr", mem_addr, mpc);
               fetch_body(16'($urandom), int'($urandom_range(1, 5)));
            end
         end
         if ($urandom_range(0, 3) == 0) tick();
      end

      repeat (3) tick();
      check16("instr_queue_drained", 16'(exp_q.size()), 16'd0);
      check16("link_queue_drained", 16'(link_q.size()), 16'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
